// File: rtl/credit_pkg.sv
// Shared constants for the credit accumulator: coin codes, coin value table, FSM encoding.
package credit_pkg;

  localparam int CREDIT_W = 8;

  localparam logic [1:0] COIN_1  = 2'b00;
  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;
  localparam logic [1:0] COIN_50 = 2'b11;

  // Indexed by coin code.
  localparam logic [3:0][CREDIT_W-1:0] COIN_TABLE = {8'd50, 8'd10, 8'd5, 8'd1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_SUB  = 2'd2
  } state_t;

endpackage

// File: rtl/coin_decoder.sv
// Combinational coin code to credit value decoder.
module coin_decoder
  import credit_pkg::*;
(
  input  logic [1:0]          code,
  output logic [CREDIT_W-1:0] value
);

  always_comb begin
    value = '0;
    unique case (code)
      COIN_1:  value = COIN_TABLE[0];
      COIN_5:  value = COIN_TABLE[1];
      COIN_10: value = COIN_TABLE[2];
      COIN_50: value = COIN_TABLE[3];
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/credit_accumulator.sv
// Coin credit accumulator with purchase/refund, using an external adder for credit updates.
// Build option: CREDIT_SATURATE_EN makes an overflowing coin saturate credit at 255 instead of rejecting.
//
// state   | meaning
// IDLE    | waiting for return/buy/coin, output_ready high
// ADD     | credit + coin value presented to the external adder
// SUB     | credit + two's complement of price presented to the adder
module credit_accumulator
  import credit_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_coin_valid,
  input  logic [1:0]        input_coin_code,
  input  logic              input_buy_valid,
  input  logic [DATA_W-1:0] input_price,
  input  logic              input_return_valid,
  output logic              output_ready,
  output logic [DATA_W-1:0] output_alu_A,
  output logic [DATA_W-1:0] output_alu_B,
  input  logic [DATA_W-1:0] input_alu_S,
  output logic [DATA_W-1:0] output_credit,
  output logic              output_reject,
  output logic              output_vend,
  output logic [DATA_W-1:0] output_change,
  output logic              output_change_valid
);

  state_t            state, state_d;
  logic [DATA_W-1:0] credit, credit_d;
  logic [DATA_W-1:0] operand, operand_d;
  logic [DATA_W-1:0] coin_value;
  logic [DATA_W-1:0] change_d;
  logic              reject_d, vend_d, change_valid_d;

  coin_decoder u_coin_decoder (
    .code  (input_coin_code),
    .value (coin_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state               <= ST_IDLE;
      credit              <= '0;
      operand             <= '0;
      output_reject       <= 1'b0;
      output_vend         <= 1'b0;
      output_change       <= '0;
      output_change_valid <= 1'b0;
    end else begin
      state               <= state_d;
      credit              <= credit_d;
      operand             <= operand_d;
      output_reject       <= reject_d;
      output_vend         <= vend_d;
      output_change       <= change_d;
      output_change_valid <= change_valid_d;
    end
  end

  always_comb begin
    state_d        = state;
    credit_d       = credit;
    operand_d      = operand;
    reject_d       = 1'b0;
    vend_d         = 1'b0;
    change_valid_d = 1'b0;
    change_d       = output_change;
    unique case (state)
      ST_IDLE: begin
        if (input_return_valid) begin
          change_d       = credit;
          change_valid_d = 1'b1;
          credit_d       = '0;
        end else if (input_buy_valid) begin
          operand_d = input_price;
          state_d   = ST_SUB;
        end else if (input_coin_valid) begin
          operand_d = coin_value;
          state_d   = ST_ADD;
        end
      end
      ST_ADD: begin
        state_d = ST_IDLE;
        // A wrapped sum is smaller than the credit it started from.
        if (input_alu_S < credit) begin
`ifdef CREDIT_SATURATE_EN
          credit_d = '1;
`else
          reject_d = 1'b1;
`endif
        end else begin
          credit_d = input_alu_S;
        end
      end
      ST_SUB: begin
        state_d = ST_IDLE;
        if (operand > credit) begin
          reject_d = 1'b1;
        end else begin
          credit_d = input_alu_S;
          vend_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    output_alu_B = '0;
    unique case (state)
      ST_ADD:  output_alu_B = operand;
      ST_SUB:  output_alu_B = (~operand) + 1'b1;
      default: output_alu_B = '0;
    endcase
  end

  assign output_ready  = (state == ST_IDLE);
  assign output_alu_A  = credit;
  assign output_credit = credit;

endmodule
